or_reduce_acc: RTL

- Parametrised successor to the team's 2-input OR gate: bitwise-ORs NUM_IN lanes of WIDTH bits each.
- Two modes: a registered pass mode, and a packet accumulate mode that ORs successive beats together until a last beat.
- Valid/ready handshake on both sides; one output register stage.
- Sits between sensor/flag sources and status logic that needs "any bit ever set" summaries.

---
 rtl/or_reduce_acc_pkg.sv | 19 +
 rtl/or_lane_reduce.sv | 20 ++
 rtl/or_reduce_acc.sv | 110 +++++++++++
 3 files changed

// File: rtl/or_reduce_acc_pkg.sv
// Shared types and helpers for the OR-reduce accumulator: FSM states, mode
// encodings and the saturating beat-counter increment.
package or_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/or_lane_reduce.sv
// Generalised OR gate: bitwise OR of NUM_IN packed lanes of WIDTH bits each.
// Lane k occupies in_data[k*WIDTH +: WIDTH].
module or_lane_reduce #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        lane_or
);

  always_comb begin
    // NOTE: assigning a default before the loop keeps this block purely
    // combinational; a path that leaves lane_or unassigned would infer a latch.
    lane_or = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      lane_or = lane_or | in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/or_reduce_acc.sv
// OR-reduce with pass and packet-accumulate modes, valid/ready on both sides
// and a single registered output stage carrying data, any-bit flag and beat count.
module or_reduce_acc
  import or_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    busy
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_e             state_q;
  logic               mode_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_any_q;
  logic [CNT_W-1:0]   out_beats_q;

  logic [WIDTH-1:0]   lane_or;
  logic [WIDTH-1:0]   fold_d;
  logic [CNT_W-1:0]   beats_d;
  logic               pkt_mode;
  logic               pkt_close;
  logic               accept;

  or_lane_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_lane_reduce (
    .in_data (in_data),
    .lane_or (lane_or)
  );

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // acc_q and cnt_q are held at zero in IDLE, so one fold/count path serves
  // both the first beat of a packet and every later one.
  assign fold_d    = acc_q | lane_or;
  assign beats_d   = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
  assign pkt_mode  = (state_q == IDLE) ? mode : mode_q;
  assign pkt_close = (pkt_mode == MODE_PASS) || in_last;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // here samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_PASS;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_any_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (clear) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (accept) begin
        if (state_q == IDLE) begin
          mode_q <= mode;
        end
        if (pkt_close) begin
          out_valid_q <= 1'b1;
          out_data_q  <= fold_d;
          out_any_q   <= |fold_d;
          out_beats_q <= beats_d;
          acc_q       <= '0;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end else begin
          acc_q   <= fold_d;
          cnt_q   <= beats_d;
          state_q <= ACC;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_any   = out_any_q;
  assign out_beats = out_beats_q;
  assign busy      = (state_q == ACC);

endmodule
